// File: rtl/stage_phase_generator.sv
// stage_phase_generator: per-slot phase accumulators, 2-stage pipeline.
// Optional key-sync phase reset is enabled by defining PHASE_KEY_SYNC_EN.
//
// Ports:
//   i_Clock                      sole clock, rising edge
//   i_Reset                      synchronous active-high reset
//   i_Valid / i_VoiceOperator    slot strobe and slot ID (op*NUM_VOICES+voice)
//   i_PhaseStepConfigWriteEnable step write to slot i_ConfigWriteAddr
//   i_NoteOnConfigWriteEnable    note-on vector write
//   i_ConfigWriteAddr/Data       config target slot and data
//   o_Ready                      clear sweep done, slots accepted
//   o_Valid                      qualifies o_Phase/o_NoteOn/o_VoiceOperator
//   o_Phase                      top OUT_WIDTH bits of the updated accumulator
//   o_NoteOn                     note-on state of the slot's voice
//   o_VoiceOperator              slot ID echoed
module stage_phase_generator #(
    parameter int PHASE_WIDTH   = 24,
    parameter int OUT_WIDTH     = 16,
    parameter int NUM_VOICES    = 32,
    parameter int NUM_OPERATORS = 8,
    localparam int NUM_SLOTS    = NUM_VOICES * NUM_OPERATORS,
    localparam int ID_WIDTH     = $clog2(NUM_SLOTS)
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic                   i_Valid,
    input  logic [ID_WIDTH-1:0]    i_VoiceOperator,
    input  logic                   i_PhaseStepConfigWriteEnable,
    input  logic                   i_NoteOnConfigWriteEnable,
    input  logic [ID_WIDTH-1:0]    i_ConfigWriteAddr,
    input  logic [PHASE_WIDTH-1:0] i_ConfigWriteData,
    output logic                   o_Ready,
    output logic                   o_Valid,
    output logic [OUT_WIDTH-1:0]   o_Phase,
    output logic                   o_NoteOn,
    output logic [ID_WIDTH-1:0]    o_VoiceOperator
);

    localparam int VOICE_W = $clog2(NUM_VOICES);
    // Note-on data is taken from as many config data bits as exist;
    // voices beyond the data width stay off.
    localparam int NV_W = (NUM_VOICES < PHASE_WIDTH) ? NUM_VOICES : PHASE_WIDTH;
    localparam logic [ID_WIDTH-1:0] LAST_SLOT = ID_WIDTH'(NUM_SLOTS - 1);

    localparam logic [0:0] ST_SWEEP = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [ID_WIDTH-1:0] sweep_cnt_q, sweep_cnt_d;
    logic                sweep_we;
    logic                fire;

    logic [PHASE_WIDTH-1:0] acc_q  [NUM_SLOTS];
    logic [PHASE_WIDTH-1:0] step_q [NUM_SLOTS];
    logic [NUM_VOICES-1:0]  noteon_q;
    logic [NUM_VOICES-1:0]  noteon_wr;

    logic                   s1_valid_q;
    logic [ID_WIDTH-1:0]    s1_id_q;
    logic [PHASE_WIDTH-1:0] s1_acc_q;
    logic [PHASE_WIDTH-1:0] s1_step_q;
    logic [PHASE_WIDTH-1:0] sum;
    logic [PHASE_WIDTH-1:0] acc_rd;
    logic [VOICE_W-1:0]     s1_voice;

    logic                 out_valid_q;
    logic [OUT_WIDTH-1:0] out_phase_q;
    logic                 out_note_q;
    logic [ID_WIDTH-1:0]  out_id_q;

    assign o_Ready  = (state_q == ST_RUN) && !i_Reset;
    assign fire     = i_Valid && o_Ready;
    assign sweep_we = (state_q == ST_SWEEP) && !i_Reset;

    assign noteon_wr = NUM_VOICES'(i_ConfigWriteData[NV_W-1:0]);
    assign sum       = s1_acc_q + s1_step_q;
    assign s1_voice  = s1_id_q[VOICE_W-1:0];

    always_comb begin
        state_d     = state_q;
        sweep_cnt_d = sweep_cnt_q;
        case (state_q)
            ST_SWEEP: begin
                sweep_cnt_d = sweep_cnt_q + ID_WIDTH'(1);
                if (sweep_cnt_q == LAST_SLOT) state_d = ST_RUN;
            end
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_SWEEP;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q     <= ST_SWEEP;
            sweep_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_cnt_q <= sweep_cnt_d;
        end
    end

`ifdef PHASE_KEY_SYNC_EN
    logic [NUM_SLOTS-1:0]  sync_q, sync_d;
    logic [NUM_VOICES-1:0] rise;

    assign rise = noteon_wr & ~noteon_q;

    // A visit consumes the flag; an arming write in the same cycle wins,
    // so it applies to the following visit.
    always_comb begin
        sync_d = sync_q;
        if (fire) sync_d[i_VoiceOperator] = 1'b0;
        if (i_NoteOnConfigWriteEnable) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (rise[s % NUM_VOICES]) sync_d[s] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) sync_q <= '0;
        else         sync_q <= sync_d;
    end
`endif

    // Back-to-back visits of one slot take the in-flight sum, since the
    // array write-back lands on the same edge as the second read.
    always_comb begin
        acc_rd = acc_q[i_VoiceOperator];
        if (s1_valid_q && (s1_id_q == i_VoiceOperator)) acc_rd = sum;
`ifdef PHASE_KEY_SYNC_EN
        if (sync_q[i_VoiceOperator]) acc_rd = '0;
`endif
    end

    always_ff @(posedge i_Clock) begin
        if (sweep_we) begin
            acc_q[sweep_cnt_q]  <= '0;
            step_q[sweep_cnt_q] <= '0;
        end else if (!i_Reset) begin
            if (s1_valid_q) acc_q[s1_id_q] <= sum;
            if (i_PhaseStepConfigWriteEnable && (state_q == ST_RUN))
                step_q[i_ConfigWriteAddr] <= i_ConfigWriteData;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            s1_acc_q    <= '0;
            s1_step_q   <= '0;
            out_valid_q <= 1'b0;
            out_phase_q <= '0;
            out_note_q  <= 1'b0;
            out_id_q    <= '0;
            noteon_q    <= '0;
        end else begin
            s1_valid_q <= fire;
            if (fire) begin
                s1_id_q   <= i_VoiceOperator;
                s1_acc_q  <= acc_rd;
                s1_step_q <= step_q[i_VoiceOperator];
            end
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_phase_q <= sum[PHASE_WIDTH-1 -: OUT_WIDTH];
                out_note_q  <= noteon_q[s1_voice];
                out_id_q    <= s1_id_q;
            end
            if (i_NoteOnConfigWriteEnable) noteon_q <= noteon_wr;
        end
    end

    assign o_Valid         = out_valid_q;
    assign o_Phase         = out_phase_q;
    assign o_NoteOn        = out_note_q;
    assign o_VoiceOperator = out_id_q;

endmodule

// File: doc/stage_phase_generator.md
STAGE_PHASE_GENERATOR -- requirements
Module: stage_phase_generator

Interface
REQ-001 SHALL have parameter PHASE_WIDTH, default 24: accumulator and phase-step width in bits.
REQ-002 SHALL have parameter OUT_WIDTH, default 16: output phase width (OUT_WIDTH <= PHASE_WIDTH).
REQ-003 SHALL have parameter NUM_VOICES, default 32: voice count, power of two, <= PHASE_WIDTH.
REQ-004 SHALL have parameter NUM_OPERATORS, default 8: operators per voice; NUM_SLOTS = NUM_VOICES*NUM_OPERATORS; ID_WIDTH = clog2(NUM_SLOTS).
REQ-005 i_Clock  in  1  sole clock; all state updates on rising edge.
REQ-006 i_Reset  in  1  reset; synchronous, active-high.
REQ-007 i_Valid  in  1  slot strobe; i_VoiceOperator is processed this cycle.
REQ-008 i_VoiceOperator  in  ID_WIDTH  slot ID = operator*NUM_VOICES + voice; voice = ID[clog2(NUM_VOICES)-1:0].
REQ-009 i_PhaseStepConfigWriteEnable  in  1  writes i_ConfigWriteData to step of slot i_ConfigWriteAddr.
REQ-010 i_NoteOnConfigWriteEnable  in  1  writes i_ConfigWriteData[NUM_VOICES-1:0] to the per-voice note-on vector.
REQ-011 i_ConfigWriteAddr  in  ID_WIDTH  config target slot.
REQ-012 i_ConfigWriteData  in  PHASE_WIDTH  config data.
REQ-013 o_Ready  out  1  high when the clear sweep is finished and slots are accepted.
REQ-014 o_Valid  out  1  qualifies o_Phase/o_NoteOn/o_VoiceOperator.
REQ-015 o_Phase  out  OUT_WIDTH  top OUT_WIDTH bits of the updated accumulator.
REQ-016 o_NoteOn  out  1  note-on state of the slot's voice.
REQ-017 o_VoiceOperator  out  ID_WIDTH  slot ID echoed.

Function
REQ-018 Latency SHALL be exactly 2 cycles from i_Valid&&o_Ready to o_Valid, one slot per cycle sustained.
REQ-019 Update SHALL be acc[id] <= (acc[id] + step[id]) mod 2^PHASE_WIDTH; unsigned wrap, no saturation.
REQ-020 o_Phase SHALL equal updated acc[PHASE_WIDTH-1 -: OUT_WIDTH] (pre-update value never output).
REQ-021 Same ID on consecutive valid cycles SHALL forward the in-flight result, so each visit advances exactly one step.
REQ-022 Step write to a slot already read into the pipeline SHALL take effect on that slot's next visit.
REQ-023 Step write and slot read of the same ID in the same cycle SHALL use the old step.
REQ-024 Note-on vector read SHALL occur in pipeline stage 1; a same-cycle write SHALL not be visible to that slot.
REQ-025 i_Valid while o_Ready is low SHALL be ignored; no state change, no o_Valid.
REQ-026 Accumulators SHALL advance regardless of note-on state, unless REQ-033 applies.

Reset
REQ-027 While i_Reset is high: o_Valid=0, o_Ready=0, o_Phase=0, o_NoteOn=0, o_VoiceOperator=0, note-on vector=0, pipeline flushed.
REQ-028 After i_Reset falls, a clear sweep SHALL write acc[n]=0 and step[n]=0 for n=0..NUM_SLOTS-1, one per cycle.
REQ-029 o_Ready SHALL rise the cycle after the last sweep write (NUM_SLOTS cycles after reset release).
REQ-030 Config writes during the sweep SHALL be dropped; note-on writes during the sweep SHALL be accepted.
REQ-031 Reset asserted mid-sweep or mid-stream SHALL abort all activity and restart the sweep on release.

Configuration
REQ-032 Macro PHASE_KEY_SYNC_EN SHALL select key-sync phase reset.
REQ-033 With PHASE_KEY_SYNC_EN: a note-on write setting a voice bit 0->1 SHALL arm a per-slot sync flag for all that voice's operators; the next visit of an armed slot SHALL use acc=0 (output = step) and clear the flag; 1->1 writes do not arm; write coinciding with a visit arms for the following visit.
REQ-034 Without PHASE_KEY_SYNC_EN: no sync flags exist; note-on only passes through to o_NoteOn.

Verification
REQ-035 Reset, release, hold i_Valid -> o_Ready low 256 cycles then high; inputs during sweep produce no o_Valid.
REQ-036 Step[5]=0x010000, visit slot 5 three times -> o_Phase 0x0100, 0x0200, 0x0300, each 2 cycles after strobe.
REQ-037 Step[7]=0xFFFF00, visit twice -> o_Phase 0xFFFF, 0xFFFE (wrap).
REQ-038 Slot 3 valid on 4 consecutive cycles, step=0x000100 -> o_Phase 0x0001,0x0002,0x0003,0x0004 (forwarding).
REQ-039 PHASE_KEY_SYNC_EN: acc[voice2,op1]=0x500000, step=0x001000, write note-on bit2 0->1, visit slot 34 -> o_Phase 0x0010, o_NoteOn=1; rewrite bit2=1 then visit -> 0x0020.
REQ-040 Assert reset mid-stream with slots in flight -> o_Valid 0 next cycle, sweep restarts, slot 5 phase 0x0000+step afterward.
